// File: rtl/instruction_memory_loader.sv
// Instruction memory for the fetch stage with a byte-serial program loader.
// Bytes are assembled little-endian into words and written sequentially until HALT or full.
module instruction_memory_loader #(
  parameter int              NB                = 32,
  parameter int              NB_BYTE           = 8,
  parameter int              N_OF_INSTRUCTIONS = 64,
  parameter logic [NB-1:0]   HALT_INSTR        = {NB{1'b1}},
  parameter int              NB_ADDR           = $clog2(N_OF_INSTRUCTIONS)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_step,
  input  logic [NB-1:0]      i_pc_address,
  output logic [NB-1:0]      o_instruction,
  output logic               o_addr_error,
  input  logic               i_load_start,
  input  logic               i_load_byte_valid,
  input  logic [NB_BYTE-1:0] i_load_byte,
  output logic               o_load_busy,
  output logic               o_load_done,
  output logic [NB_ADDR:0]   o_words_loaded,
  output logic               o_overflow
);

  localparam int                 N_LANES    = NB / NB_BYTE;
  localparam int                 NB_LANE    = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [NB_LANE-1:0] LAST_LANE  = NB_LANE'(N_LANES - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR  = NB_ADDR'(N_OF_INSTRUCTIONS - 1);
  localparam logic [NB_ADDR:0]   FULL_COUNT = (NB_ADDR + 1)'(N_OF_INSTRUCTIONS);
  localparam logic [NB-1:0]      ADDR_LIMIT = NB'(4 * N_OF_INSTRUCTIONS);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t               state;
  logic [NB_ADDR-1:0]   word_ptr;
  logic [NB_LANE-1:0]   byte_cnt;
  logic [NB-1:0]        assembly;
  logic [NB-1:0]        asm_word;
  logic                 last_byte;
  logic                 word_write;
  logic                 fetch_en;
  logic                 fetch_bad;
  logic [NB-1:0]        mem [N_OF_INSTRUCTIONS];

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    asm_word = assembly;
    for (int lane = 0; lane < N_LANES; lane++) begin
      if (byte_cnt == NB_LANE'(lane)) asm_word[lane*NB_BYTE +: NB_BYTE] = i_load_byte;
    end
  end

  assign last_byte   = (byte_cnt == LAST_LANE);
  assign word_write  = (state == LOAD) && !i_load_start && i_load_byte_valid && last_byte;
  assign fetch_en    = i_step && (state != LOAD);
  assign fetch_bad   = (|i_pc_address[1:0]) || (i_pc_address >= ADDR_LIMIT);
  assign o_load_busy = (state == LOAD);
  assign o_load_done = (state == DONE);

  // NOTE: the memory array has no reset; clearing it would force flops instead of RAM.
  always_ff @(posedge i_clock) begin
    if (word_write) mem[word_ptr] <= asm_word;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      word_ptr       <= '0;
      byte_cnt       <= '0;
      assembly       <= '0;
      o_words_loaded <= '0;
      o_overflow     <= 1'b0;
    end else if (i_load_start) begin
      // A start from any state opens a fresh session; a same-cycle byte is dropped.
      state          <= LOAD;
      word_ptr       <= '0;
      byte_cnt       <= '0;
      assembly       <= '0;
      o_words_loaded <= '0;
      o_overflow     <= 1'b0;
    end else if (state == LOAD && i_load_byte_valid) begin
      byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
      assembly <= last_byte ? '0 : asm_word;
      if (last_byte) begin
        word_ptr <= word_ptr + 1'b1;
        if (o_words_loaded != FULL_COUNT) o_words_loaded <= o_words_loaded + 1'b1;
        if (asm_word == HALT_INSTR) begin
          state <= DONE;
        end else if (word_ptr == LAST_ADDR) begin
          o_overflow <= 1'b1;
          state      <= DONE;
        end
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_instruction <= '0;
      o_addr_error  <= 1'b0;
    end else if (fetch_en) begin
      o_instruction <= fetch_bad ? '0 : mem[i_pc_address[NB_ADDR+1:2]];
      o_addr_error  <= fetch_bad;
    end
  end

endmodule

// File: doc/instruction_memory_loader.md
Name: instruction_memory_loader

Overview:
Parametrised instruction memory for the fetch stage, with a byte-serial program loader driven by the debug unit. The loader assembles bytes into little-endian words, writes them sequentially from word 0, and stops on a HALT word or when the memory is full. The fetch port gives a registered read gated by a step enable, which supports continuous and step-by-step execution.

Parameters:
NB, 32, instruction/data word width in bits (multiple of NB_BYTE)
NB_BYTE, 8, loader byte width
N_OF_INSTRUCTIONS, 64, memory depth in words (power of two)
HALT_INSTR, 32'hFFFF_FFFF, word that terminates a load session
NB_ADDR, $clog2(N_OF_INSTRUCTIONS), word-index width (derived)

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_step  in  1  fetch enable; high = perform one read this edge
i_pc_address  in  NB  fetch byte address
o_instruction  out  NB  registered fetched instruction
o_addr_error  out  1  registered; last fetch was misaligned or out of range
i_load_start  in  1  start a new load session (debug unit)
i_load_byte_valid  in  1  i_load_byte is valid this cycle
i_load_byte  in  NB_BYTE  program byte, LSB-first within a word
o_load_busy  out  1  high while in LOAD
o_load_done  out  1  high while in DONE
o_words_loaded  out  NB_ADDR+1  words written in the current/last session
o_overflow  out  1  last session filled memory without seeing HALT_INSTR

Behaviour:
- Reset (async, any time, including mid-load): o_instruction=0, o_addr_error=0, state=IDLE, o_load_busy=0, o_load_done=0, o_words_loaded=0, o_overflow=0, byte counter=0, assembly register=0. Memory array contents are not reset; they retain previous values or are X after power-up. A partial word is discarded.
- FSM states: IDLE, LOAD, DONE. o_load_busy=(state==LOAD) and o_load_done=(state==DONE), both decoded from state.
- IDLE/DONE with i_load_start=1 -> LOAD next edge. On that edge: word pointer=0, byte counter=0, o_words_loaded=0, o_overflow=0.
- LOAD with i_load_start=1 restarts the session with the same clearing. i_load_start has priority over a byte in the same cycle; that byte is dropped.
- LOAD with i_load_byte_valid=1: the byte goes to lane byte_counter, where lane 0 is bits [7:0]. The byte counter increments modulo NB/NB_BYTE.
- On the last lane, the assembled word including the current byte is written to mem[pointer] on the same edge. The pointer and o_words_loaded increment.
  - If the word == HALT_INSTR, the HALT word is stored and counted, and the next state is DONE.
  - Otherwise, if pointer+1 == N_OF_INSTRUCTIONS, o_overflow is set to 1 and the next state is DONE.
- Bytes in IDLE/DONE are ignored. Bytes with valid=0 are ignored in every state.
- Fetch: on an edge with i_step=1 and state!=LOAD, the block registers a read. Latency is 1 cycle.
  - Error case: if i_pc_address[1:0]!=0 or i_pc_address >= 4*N_OF_INSTRUCTIONS, then o_instruction=0 (NOP) and o_addr_error=1.
  - Normal case: o_instruction=mem[i_pc_address[NB_ADDR+1:2]] and o_addr_error=0.
- i_step=0, or state==LOAD: o_instruction and o_addr_error hold their values.
- A fetch is never performed in the same cycle as a write. Words written in a session are visible to the first fetch after entering DONE.
- o_words_loaded saturates at N_OF_INSTRUCTIONS. It needs NB_ADDR+1 bits so that the full count is representable.

Test Plan:
- Reset, pulse i_load_start, then bytes 13,00,20,00 and FF,FF,FF,FF. Required: mem[0]=32'h0020_0013, mem[1]=HALT. DONE reached the edge after the 8th byte, o_words_loaded=2, o_overflow=0. Then fetch pc=0 with i_step=1 -> o_instruction=32'h0020_0013 one cycle later.
- Step gating: after the load above, hold i_step=0 while changing pc to 4. Required: o_instruction stays 32'h0020_0013. Then one i_step=1 cycle -> o_instruction=32'hFFFF_FFFF.
- Address errors: fetch pc=2 -> o_instruction=0 and o_addr_error=1. Fetch pc=256 (N=64) -> 0 and error=1. Fetch pc=4 -> error=0.
- Overflow: load 64 non-HALT words (word k = k+1). Required: DONE, o_overflow=1, o_words_loaded=64. Extra bytes ignored. Fetch pc=252 -> 64.
- Restart and abort: in LOAD after 2 bytes, assert i_load_start together with a valid byte. Required: counters cleared, byte dropped, a following 4-byte word goes to mem[0].
- Async reset mid-load: reset asserted between clock edges after 6 bytes. Required: outputs go to reset values immediately, state IDLE, and fetch works after deassertion.
